// File: rtl/lsu_store_queue_if.sv
// Store queue port bundle: push, commit/flush, drain and load-forward channels.
// master drives requests and consumes responses; slave is the store queue.
interface lsu_store_queue_if #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 64,
    parameter int ID_W  = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // push channel
    logic              push_valid;
    logic              push_ready;
    logic [ID_W-1:0]   push_id;
    logic [XLEN-1:0]   push_paddr;
    logic [1:0]        push_size;
    logic [XLEN-1:0]   push_data;

    // retirement control
    logic              commit;
    logic              flush;

    // drain channel to dcache
    logic              drain_valid;
    logic              drain_ready;
    logic [ID_W-1:0]   drain_id;
    logic [XLEN-1:0]   drain_paddr;
    logic [1:0]        drain_size;
    logic [XLEN-1:0]   drain_data;

    // load forwarding lookup
    logic              fwd_valid;
    logic [XLEN-1:0]   fwd_paddr;
    logic [1:0]        fwd_size;
    logic              fwd_hit;
    logic              fwd_stall;
    logic [XLEN-1:0]   fwd_data;

    // occupancy
    logic [CNT_W-1:0]  count;
    logic              empty;

    modport master (
        output push_valid, push_id, push_paddr, push_size, push_data,
        output commit, flush, drain_ready,
        output fwd_valid, fwd_paddr, fwd_size,
        input  push_ready, drain_valid, drain_id, drain_paddr, drain_size, drain_data,
        input  fwd_hit, fwd_stall, fwd_data, count, empty
    );

    modport slave (
        input  push_valid, push_id, push_paddr, push_size, push_data,
        input  commit, flush, drain_ready,
        input  fwd_valid, fwd_paddr, fwd_size,
        output push_ready, drain_valid, drain_id, drain_paddr, drain_size, drain_data,
        output fwd_hit, fwd_stall, fwd_data, count, empty
    );
endinterface

// File: rtl/lsu_store_queue.sv
// In-order store queue with commit tracking, dcache drain and store-to-load forwarding.
// Latency: push/commit/flush/drain visible next cycle; forwarding is combinational.
// Backpressure: push_ready from registered occupancy only; drain holds until drain_ready.
module lsu_store_queue #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 64,
    parameter int ID_W  = 8
) (
    input  logic             clk,
    input  logic             rstn,
    lsu_store_queue_if.slave sq
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [XLEN-1:0] paddr;
        logic [1:0]      size;
        logic [XLEN-1:0] data;
        logic [7:0]      mask;
    } sq_entry_t;

    sq_entry_t      mem [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  cmt;
    logic [PW-1:0]  tail;
    logic [PW-1:0]  count;
    logic [PW-1:0]  cmt_nxt;
    logic [PW-1:0]  tail_nxt;
    logic [AW-1:0]  head_idx;

    logic           push_ready;
    logic           push_fire;
    logic           push_cross;
    logic [7:0]     push_mask;
    logic           drain_valid;
    logic           drain_fire;
    logic           commit_fire;

    logic [7:0]     ld_mask;
    logic [XLEN-1:0] ld_bits;
    logic           fwd_found;
    logic [AW-1:0]  fwd_sel;
    logic [AW-1:0]  scan_idx;
    logic           fwd_cover;
    logic [5:0]     fwd_shift;

    function automatic logic [7:0] byte_mask(input logic [2:0] off, input logic [1:0] size);
        logic [7:0] base;
        base = 8'hFF;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

    function automatic logic [XLEN-1:0] size_bits(input logic [1:0] size);
        logic [XLEN-1:0] bits;
        bits = '1;
        case (size)
            2'd0:    bits = XLEN'(64'h0000_0000_0000_00FF);
            2'd1:    bits = XLEN'(64'h0000_0000_0000_FFFF);
            2'd2:    bits = XLEN'(64'h0000_0000_FFFF_FFFF);
            default: bits = '1;
        endcase
        return bits;
    endfunction

    // Occupancy and handshakes, all from registered pointers.
    assign count       = tail - head;
    assign head_idx    = head[AW-1:0];
    assign push_ready  = (count < PW'(DEPTH));
    assign drain_valid = (head != cmt);

    assign push_fire   = sq.push_valid && push_ready && !sq.flush;
    assign drain_fire  = drain_valid && sq.drain_ready;
    assign commit_fire = sq.commit && (cmt != tail);

    assign push_mask   = byte_mask(sq.push_paddr[2:0], sq.push_size);
    assign push_cross  = ({1'b0, sq.push_paddr[2:0]} + (4'd1 << sq.push_size)) > 4'd8;

    // Flush rewinds tail to the commit point after this cycle's commit.
    assign cmt_nxt  = cmt + PW'(commit_fire);
    assign tail_nxt = sq.flush ? cmt_nxt : (tail + PW'(push_fire));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head <= '0;
            cmt  <= '0;
            tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (drain_fire) begin
                head <= head + PW'(1);
            end
            cmt  <= cmt_nxt;
            tail <= tail_nxt;
            if (push_fire) begin
                mem[tail[AW-1:0]] <= '{id:    sq.push_id,
                                       paddr: sq.push_paddr,
                                       size:  sq.push_size,
                                       data:  sq.push_data,
                                       mask:  push_mask};
            end
        end
    end

    assign sq.push_ready  = push_ready;
    assign sq.drain_valid = drain_valid;
    assign sq.drain_id    = mem[head_idx].id;
    assign sq.drain_paddr = mem[head_idx].paddr;
    assign sq.drain_size  = mem[head_idx].size;
    assign sq.drain_data  = mem[head_idx].data;
    assign sq.count       = count;
    assign sq.empty       = (count == '0);

    // Walk oldest to youngest so the last overlapping entry wins.
    assign ld_mask = byte_mask(sq.fwd_paddr[2:0], sq.fwd_size);
    assign ld_bits = size_bits(sq.fwd_size);

    always_comb begin
        fwd_found = 1'b0;
        fwd_sel   = '0;
        scan_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_idx + AW'(k);
            if ((PW'(k) < count) &&
                (mem[scan_idx].paddr[XLEN-1:3] == sq.fwd_paddr[XLEN-1:3]) &&
                (|(mem[scan_idx].mask & ld_mask))) begin
                fwd_found = 1'b1;
                fwd_sel   = scan_idx;
            end
        end
    end

    assign fwd_cover = ((mem[fwd_sel].mask & ld_mask) == ld_mask);
    assign fwd_shift = {sq.fwd_paddr[2:0] - mem[fwd_sel].paddr[2:0], 3'b000};

    assign sq.fwd_hit   = sq.fwd_valid && fwd_found && fwd_cover;
    assign sq.fwd_stall = sq.fwd_valid && fwd_found && !fwd_cover;
    assign sq.fwd_data  = (sq.fwd_valid && fwd_found && fwd_cover)
                        ? ((mem[fwd_sel].data >> fwd_shift) & ld_bits)
                        : '0;

    a_no_dword_cross: assert property (@(posedge clk) disable iff (!rstn)
        push_fire |-> !push_cross);

    a_commit_has_spec: assert property (@(posedge clk) disable iff (!rstn)
        sq.commit |-> (cmt != tail));
endmodule

// File: tb/tb_lsu_store_queue.sv
// Directed bench for lsu_store_queue with a queue-based reference model.
module tb_lsu_store_queue;
    localparam int DEPTH = 8;
    localparam int XLEN  = 64;
    localparam int ID_W  = 8;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    lsu_store_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN), .ID_W(ID_W)) sq();

    lsu_store_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .ID_W(ID_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .sq   (sq)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  id;
        logic [63:0] addr;
        logic [1:0]  size;
        logic [63:0] data;
    } ent_t;

    ent_t q[$];
    int   ncmt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%h expected=0x%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Byte-granular forwarding reference: youngest store touching any load byte decides.
    function automatic void model_fwd(output logic hit, output logic stall, output logic [63:0] data);
        logic [63:0] a, sa, sd, ba;
        int nb, sb, off;
        bit any_in, all_in, inb;
        hit = 1'b0; stall = 1'b0; data = '0;
        if (!sq.fwd_valid) return;
        a  = sq.fwd_paddr;
        nb = 1 << sq.fwd_size;
        for (int i = q.size() - 1; i >= 0; i--) begin
            sa = q[i].addr; sb = 1 << q[i].size; sd = q[i].data;
            any_in = 1'b0; all_in = 1'b1;
            for (int j = 0; j < nb; j++) begin
                ba  = a + 64'(j);
                inb = (ba >= sa) && (ba < sa + 64'(sb));
                any_in = any_in | inb;
                all_in = all_in & inb;
            end
            if (any_in) begin
                if (all_in) begin
                    hit = 1'b1;
                    for (int j = 0; j < nb; j++) begin
                        off = int'(a + 64'(j) - sa);
                        data[8*j +: 8] = sd[8*off +: 8];
                    end
                end else begin
                    stall = 1'b1;
                end
                return;
            end
        end
    endfunction

    // Reference state update: drain, then commit, then flush; push dropped under flush.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q.delete();
            ncmt = 0;
        end else begin
            automatic bit   full  = (q.size() >= DEPTH);
            automatic bit   do_dr = (ncmt > 0) && sq.drain_ready;
            automatic bit   do_cm = sq.commit && (q.size() > ncmt);
            automatic bit   do_pu = sq.push_valid && !full && !sq.flush;
            automatic ent_t e;
            if (do_dr) begin
                void'(q.pop_front());
                ncmt--;
            end
            if (do_cm) ncmt++;
            if (sq.flush) begin
                while (q.size() > ncmt) void'(q.pop_back());
            end else if (do_pu) begin
                e.id = sq.push_id; e.addr = sq.push_paddr;
                e.size = sq.push_size; e.data = sq.push_data;
                q.push_back(e);
            end
        end
    end

    logic        exp_hit, exp_stall;
    logic [63:0] exp_data;

    always @(negedge clk) begin
        model_fwd(exp_hit, exp_stall, exp_data);
        chk("m_push_ready", 64'(sq.push_ready), 64'(q.size() < DEPTH));
        chk("m_drain_valid", 64'(sq.drain_valid), 64'(ncmt > 0));
        chk("m_count", 64'(sq.count), 64'(q.size()));
        chk("m_empty", 64'(sq.empty), 64'(q.size() == 0));
        chk("m_fwd_hit", 64'(sq.fwd_hit), 64'(exp_hit));
        chk("m_fwd_stall", 64'(sq.fwd_stall), 64'(exp_stall));
        chk("m_fwd_data", sq.fwd_data, exp_data);
        if (ncmt > 0) begin
            chk("m_drain_id", 64'(sq.drain_id), 64'(q[0].id));
            chk("m_drain_paddr", sq.drain_paddr, q[0].addr);
            chk("m_drain_size", 64'(sq.drain_size), 64'(q[0].size));
            chk("m_drain_data", sq.drain_data, q[0].data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sq.push_valid = 1'b0; sq.push_id = '0; sq.push_paddr = '0;
        sq.push_size = '0; sq.push_data = '0;
        sq.commit = 1'b0; sq.flush = 1'b0; sq.drain_ready = 1'b0;
        sq.fwd_valid = 1'b0; sq.fwd_paddr = '0; sq.fwd_size = '0;
    endtask

    task automatic push(input logic [7:0] id, input logic [63:0] addr,
                        input logic [1:0] size, input logic [63:0] data);
        sq.push_valid = 1'b1; sq.push_id = id; sq.push_paddr = addr;
        sq.push_size = size; sq.push_data = data;
        step();
        sq.push_valid = 1'b0;
    endtask

    task automatic lookup(input logic [63:0] addr, input logic [1:0] size);
        sq.fwd_valid = 1'b1; sq.fwd_paddr = addr; sq.fwd_size = size;
        @(negedge clk);
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_push_ready", 64'(sq.push_ready), 64'd1);
        chk("rst_drain_valid", 64'(sq.drain_valid), 64'd0);
        chk("rst_empty", 64'(sq.empty), 64'd1);
        chk("rst_count", 64'(sq.count), 64'd0);
        chk("rst_drain_paddr", sq.drain_paddr, 64'd0);
        chk("rst_fwd_data", sq.fwd_data, 64'd0);
        step();
        rstn = 1'b1;

        // Three stores, commit all, drain back to back
        for (int k = 0; k < 3; k++) push(8'(k + 1), 64'h100 + 64'(8 * k), 2'd3, 64'hA0 + 64'(k));
        sq.commit = 1'b1;
        repeat (3) step();
        sq.commit = 1'b0;
        sq.drain_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("drain_seq_valid", 64'(sq.drain_valid), 64'd1);
            chk("drain_seq_paddr", sq.drain_paddr, 64'h100 + 64'(8 * k));
        end
        @(negedge clk);
        chk("drain_seq_empty", 64'(sq.empty), 64'd1);
        step();
        sq.drain_ready = 1'b0;

        // Forwarding: full hit, partial stall, youngest wins, miss
        push(8'd4, 64'h1000, 2'd3, 64'h1122334455667788);
        lookup(64'h1004, 2'd2);
        chk("lw_hit", 64'(sq.fwd_hit), 64'd1);
        chk("lw_data", sq.fwd_data, 64'h11223344);
        chk("lw_stall", 64'(sq.fwd_stall), 64'd0);
        push(8'd5, 64'h1003, 2'd0, 64'h5A);
        lookup(64'h1002, 2'd2);
        chk("partial_stall", 64'(sq.fwd_stall), 64'd1);
        chk("partial_hit", 64'(sq.fwd_hit), 64'd0);
        lookup(64'h1003, 2'd0);
        chk("sb_fwd_data", sq.fwd_data, 64'h5A);
        lookup(64'h1007, 2'd0);
        chk("lb_top_byte", sq.fwd_data, 64'h11);
        lookup(64'h3000, 2'd3);
        chk("miss_hit", 64'(sq.fwd_hit), 64'd0);
        push(8'd6, 64'h2000, 2'd0, 64'hAA);
        push(8'd7, 64'h2000, 2'd0, 64'hBB);
        lookup(64'h2000, 2'd0);
        chk("youngest_data", sq.fwd_data, 64'hBB);
        lookup(64'h1000, 2'd1);
        chk("lh_data", sq.fwd_data, 64'h7788);
        step();
        sq.fwd_valid = 1'b0;

        sq.commit = 1'b1; sq.drain_ready = 1'b1;
        repeat (4) step();
        sq.commit = 1'b0;
        for (int n = 0; n < 20 && !sq.empty; n++) step();
        @(negedge clk);
        chk("drain_all_empty", 64'(sq.empty), 64'd1);
        step();
        sq.drain_ready = 1'b0;

        // Fill, reject when full, commit two, flush
        for (int k = 0; k < DEPTH; k++) push(8'(8 + k), 64'h3000 + 64'(8 * k), 2'd3, 64'h0101010101010101 * 64'(k));
        @(negedge clk);
        chk("full_count", 64'(sq.count), 64'(DEPTH));
        chk("full_ready", 64'(sq.push_ready), 64'd0);
        push(8'd99, 64'h4000, 2'd3, 64'hDEAD);
        @(negedge clk);
        chk("full_reject", 64'(sq.count), 64'(DEPTH));
        sq.commit = 1'b1;
        repeat (2) step();
        sq.commit = 1'b0;
        sq.flush = 1'b1;
        step();
        sq.flush = 1'b0;
        @(negedge clk);
        chk("flush_count", 64'(sq.count), 64'd2);
        chk("flush_ready", 64'(sq.push_ready), 64'd1);
        lookup(64'h3010, 2'd3);
        chk("flushed_no_fwd", 64'(sq.fwd_hit), 64'd0);
        lookup(64'h3008, 2'd3);
        chk("kept_fwd", sq.fwd_data, 64'h0101010101010101);
        step();
        sq.fwd_valid = 1'b0;

        // Full queue: drain accepted, push rejected in the same cycle
        for (int k = 0; k < 6; k++) push(8'(20 + k), 64'h5000 + 64'(8 * k), 2'd3, 64'h50 + 64'(k));
        @(negedge clk);
        chk("refill_count", 64'(sq.count), 64'(DEPTH));
        sq.drain_ready = 1'b1;
        push(8'd30, 64'h6000, 2'd3, 64'h60);
        sq.drain_ready = 1'b0;
        @(negedge clk);
        chk("full_drain_count", 64'(sq.count), 64'(DEPTH - 1));
        chk("full_drain_head", sq.drain_paddr, 64'h3008);

        // Push, commit, drain and flush together
        sq.drain_ready = 1'b1; sq.commit = 1'b1; sq.flush = 1'b1;
        push(8'd31, 64'h6100, 2'd3, 64'h61);
        sq.drain_ready = 1'b0; sq.commit = 1'b0; sq.flush = 1'b0;
        @(negedge clk);
        chk("all4_count", 64'(sq.count), 64'd1);
        chk("all4_head", sq.drain_paddr, 64'h5000);

        // Reset while draining with five committed entries
        for (int k = 0; k < 4; k++) push(8'(40 + k), 64'h7000 + 64'(8 * k), 2'd3, 64'h70 + 64'(k));
        sq.commit = 1'b1;
        repeat (4) step();
        sq.commit = 1'b0;
        sq.drain_ready = 1'b1;
        sq.fwd_valid = 1'b1; sq.fwd_paddr = 64'h7008; sq.fwd_size = 2'd3;
        #3;
        chk("pre_rst_count", 64'(sq.count), 64'd5);
        chk("pre_rst_hit", 64'(sq.fwd_hit), 64'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_count", 64'(sq.count), 64'd0);
        chk("mid_rst_empty", 64'(sq.empty), 64'd1);
        chk("mid_rst_dvalid", 64'(sq.drain_valid), 64'd0);
        chk("mid_rst_ready", 64'(sq.push_ready), 64'd1);
        chk("mid_rst_paddr", sq.drain_paddr, 64'd0);
        chk("mid_rst_hit", 64'(sq.fwd_hit), 64'd0);
        chk("mid_rst_data", sq.fwd_data, 64'd0);
        idle();
        step();
        rstn = 1'b1;
        push(8'd50, 64'h8000, 2'd3, 64'hCAFE);
        sq.commit = 1'b1;
        step();
        sq.commit = 1'b0;
        @(negedge clk);
        chk("post_rst_dvalid", 64'(sq.drain_valid), 64'd1);
        chk("post_rst_paddr", sq.drain_paddr, 64'h8000);
        chk("post_rst_data", sq.drain_data, 64'hCAFE);
        sq.drain_ready = 1'b1;
        step();
        sq.drain_ready = 1'b0;
        @(negedge clk);
        chk("final_empty", 64'(sq.empty), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lsu_store_queue.md
# lsu_store_queue

Parametrised store queue for the load/store unit. It buffers translated stores in program order and tracks each one as speculative or committed. Committed stores drain to the dcache write port through a valid/ready handshake. Each cycle it resolves one load lookup by store-to-load forwarding (full hit, stall, or miss), and it drops all speculative stores on a pipeline flush.

## Interface
Parameters:
- DEPTH, 8, number of entries; power of two, ≥2
- XLEN, 64, address/data width; 64 only (dword forwarding granule)
- ID_W, 8, instruction id width

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous active-low reset
- push_valid_i  in  1  new translated store
- push_ready_o  out  1  queue not full
- push_id_i  in  ID_W  store instruction id
- push_paddr_i  in  XLEN  physical address
- push_size_i  in  2  0=B 1=H 2=W 3=D
- push_data_i  in  XLEN  store data, low-aligned (byte 0 at bit 0)
- commit_i  in  1  oldest speculative entry becomes committed
- flush_i  in  1  discard all speculative entries
- drain_valid_o  out  1  oldest entry committed and ready to write
- drain_ready_i  in  1  dcache accepts write
- drain_id_o / drain_paddr_o / drain_size_o / drain_data_o  out  ID_W/XLEN/2/XLEN  head entry payload
- fwd_valid_i  in  1  load lookup request
- fwd_paddr_i  in  XLEN  load physical address
- fwd_size_i  in  2  load size
- fwd_hit_o  out  1  forwarding successful
- fwd_stall_o  out  1  partial overlap; load must replay
- fwd_data_o  out  XLEN  forwarded bytes, low-aligned, zero-extended
- count_o  out  $clog2(DEPTH)+1  occupied entries
- empty_o  out  1  count_o == 0

## Operation
- Three pointers with wrap bit: head (drain), cmt (first speculative entry), tail (next free). Order: head ≤ cmt ≤ tail.
- Push: entry written at tail when push_valid_i && push_ready_o && !flush_i. Entry stores id, paddr, size, data, and byte mask.
- Byte mask = size bytes starting at paddr[2:0]. A store crossing a dword boundary is illegal and is flagged by an assertion.
- Commit: cmt advances when commit_i && cmt != tail. commit_i with no speculative entry is ignored and flagged by an assertion.
- Flush: tail ← cmt after any same-cycle commit is applied. Committed entries survive. A push in the same cycle as a flush is dropped.
- Drain: drain_valid_o = (head != cmt). head advances on drain_valid_o && drain_ready_i. Payload outputs show the head entry.
- Forwarding:
  - Loads issue in program order with stores, so every valid entry (head..tail-1, committed or not) is older than the load.
  - An entry overlaps the load when paddr[XLEN-1:3] matches and the byte masks intersect. Only the youngest overlapping entry is considered.
  - If that entry's mask covers the load mask: fwd_hit_o=1, fwd_data_o = store data shifted right by 8×(load_off−store_off), with bytes above the load size zeroed.
  - If the mask only partially covers the load: fwd_stall_o=1, fwd_hit_o=0.
  - No overlap, or fwd_valid_i=0: both flags 0 and fwd_data_o=0.
- count_o = tail − head, computed with wrap bits.

## Timing
- Reset (asynchronous):
  - all pointers and storage are 0
  - push_ready_o=1, drain_valid_o=0, fwd_hit_o=0, fwd_stall_o=0, empty_o=1, count_o=0
  - payload outputs and fwd_data_o read 0
- Push, commit, flush and drain take effect at the rising edge. Their results are visible on outputs the following cycle.
- push_ready_o is derived from registered state only (count_o < DEPTH). A same-cycle drain does not create room. A full queue accepts no push even when drain_ready_i=1.
- A pushed store is forwardable from the cycle after the push. It can drain at the earliest 1 cycle after its commit edge.
- The forwarding path is purely combinational, with a single-cycle result.
- drain_valid_o stays asserted, with stable payload, until accepted. Flush never withdraws a committed head.
- Push, commit, drain and flush may all occur in the same cycle. Apply drain, then commit, then flush; the push is dropped.
- Pointer wrap at DEPTH: the wrap bit distinguishes full (indices equal, wrap bits differ) from empty.

## Test plan
- Reset → push 3 stores, commit 3, drain_ready_i=1 → drain_valid_o high for 3 consecutive cycles, addresses in push order, then empty_o=1.
- Push SD 0x1000 data 0x1122334455667788, then LW lookup at 0x1004 → fwd_hit_o=1, fwd_data_o=0x11223344. LW at 0x1002 against SB 0x1003 → fwd_stall_o=1.
- Push SB 0x2000=0xAA then SB 0x2000=0xBB; LB lookup at 0x2000 → hit with data 0xBB (youngest entry wins).
- Fill DEPTH entries, commit 2, flush → count_o=2, push_ready_o=1; the flushed addresses no longer forward.
- Full queue with push_valid_i and drain accepted in the same cycle → push rejected, count_o=DEPTH−1 next cycle.
- Assert rstn mid-drain with 5 entries queued → all outputs at reset values immediately; first push after reset lands at index 0.
